// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler
// Raster counters, sync generation and TMDS period sequencing for the three
// HDMI channel encoders. Every output is registered and coherent with x/y.
// Data-island support (island FSM, packet-slot handshake, DI_PRE control
// code) is compiled in only when HDMI_DATA_ISLAND_EN is defined; without it
// the block is a plain DVI scheduler and pkt_valid is ignored.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE      = 1280,
    parameter int H_FRONT       = 110,
    parameter int H_SYNC        = 40,
    parameter int H_BACK        = 220,
    parameter int V_ACTIVE      = 720,
    parameter int V_FRONT       = 5,
    parameter int V_SYNC        = 5,
    parameter int V_BACK        = 20,
    parameter int ISLAND_OFFSET = 4,
    parameter int MAX_PACKETS   = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enableVsync,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    output logic [4:0]  pkt_word,
    output logic [2:0]  period,
    output logic [3:0]  ctl,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Period codes as seen by the channel encoders
    localparam logic [2:0] P_CTRL        = 3'd0;
    localparam logic [2:0] P_VID_PRE     = 3'd1;
    localparam logic [2:0] P_VID_GB      = 3'd2;
    localparam logic [2:0] P_VIDEO       = 3'd3;
    localparam logic [2:0] P_DI_PRE      = 3'd4;
    localparam logic [2:0] P_DI_GB_LEAD  = 3'd5;
    localparam logic [2:0] P_DI          = 3'd6;
    localparam logic [2:0] P_DI_GB_TRAIL = 3'd7;

    localparam logic [3:0] CTL_VID_PRE = 4'b0001;

    // Raster landmarks, pre-sized to the counter width
    localparam logic [11:0] X_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] Y_LAST       = 12'(V_TOTAL - 1);
    localparam logic [11:0] X_ACT_END    = 12'(H_ACTIVE);
    localparam logic [11:0] Y_ACT_END    = 12'(V_ACTIVE);
    localparam logic [11:0] X_HS_START   = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] X_HS_END     = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] Y_VS_START   = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] Y_VS_END     = 12'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [11:0] X_VPRE_START = 12'(H_TOTAL - 10);
    localparam logic [11:0] X_VPRE_END   = 12'(H_TOTAL - 3);
    localparam logic [11:0] X_VGB_START  = 12'(H_TOTAL - 2);

    // Reject geometries where an island could collide with the video leader
    // or where the counters cannot hold the raster.
    if (ISLAND_OFFSET < 4 || MAX_PACKETS < 1 || MAX_PACKETS > 18 ||
        (ISLAND_OFFSET + 10 + 32 * MAX_PACKETS + 2 + 12) > (H_TOTAL - H_ACTIVE - 10) ||
        H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_params
        $error("hdmi_period_scheduler: no room for the data island before the video leader");
    end

    logic [11:0] x_reg;
    logic [11:0] y_reg;
    logic [11:0] x_next;
    logic [11:0] y_next;
    logic [11:0] y_after_next;
    logic        hsync_reg;
    logic        vsync_reg;
    logic        de_reg;
    logic        video_next;
    logic        lead_line_next;
    logic        vid_pre_next;
    logic        vid_gb_next;
    logic [2:0]  base_period_next;
    logic [3:0]  base_ctl_next;
    logic [2:0]  period_reg;
    logic [3:0]  ctl_reg;

    // Next raster position and the non-island period it implies
    always_comb begin
        x_next = x_reg + 12'd1;
        y_next = y_reg;
        if (x_reg == X_LAST) begin
            x_next = 12'd0;
            y_next = (y_reg == Y_LAST) ? 12'd0 : (y_reg + 12'd1);
        end
        y_after_next   = (y_next == Y_LAST) ? 12'd0 : (y_next + 12'd1);
        video_next     = (x_next < X_ACT_END) && (y_next < Y_ACT_END);
        lead_line_next = (y_after_next < Y_ACT_END);
        vid_pre_next   = lead_line_next && (x_next >= X_VPRE_START) && (x_next <= X_VPRE_END);
        vid_gb_next    = lead_line_next && (x_next >= X_VGB_START);

        base_period_next = P_CTRL;
        base_ctl_next    = 4'b0000;
        if (video_next) begin
            base_period_next = P_VIDEO;
        end else if (vid_pre_next) begin
            base_period_next = P_VID_PRE;
            base_ctl_next    = CTL_VID_PRE;
        end else if (vid_gb_next) begin
            base_period_next = P_VID_GB;
        end
    end

    // Raster counters and syncs, registered against the next position
    always_ff @(posedge pclk) begin
        if (rst) begin
            x_reg     <= 12'd0;
            y_reg     <= 12'd0;
            hsync_reg <= 1'b0;
            vsync_reg <= 1'b0;
            de_reg    <= 1'b0;
        end else begin
            x_reg     <= x_next;
            y_reg     <= y_next;
            hsync_reg <= (x_next >= X_HS_START) && (x_next < X_HS_END);
            vsync_reg <= enableVsync && (y_next >= Y_VS_START) && (y_next < Y_VS_END);
            de_reg    <= video_next;
        end
    end

`ifdef HDMI_DATA_ISLAND_EN

    localparam logic [3:0]  CTL_DI_PRE   = 4'b0101;
    localparam logic [11:0] X_ISL_DECIDE = 12'(H_ACTIVE + ISLAND_OFFSET - 1);
    localparam logic [4:0]  PKT_LIMIT    = 5'(MAX_PACKETS);

    typedef enum logic [2:0] {
        ISL_IDLE,
        ISL_PRE,
        ISL_GBL,
        ISL_PKT,
        ISL_GBT
    } isl_state_t;

    isl_state_t  isl_state_reg;
    logic [2:0]  isl_cnt_reg;
    logic [4:0]  pkt_cnt_reg;
    logic        pkt_ready_reg;
    logic [4:0]  pkt_word_reg;

    // Island FSM; the island never overlaps video (it starts after the active
    // region) nor the leader (guaranteed by the room check), so island states
    // simply override the raster-derived period while they run.
    always_ff @(posedge pclk) begin
        if (rst) begin
            isl_state_reg <= ISL_IDLE;
            isl_cnt_reg   <= 3'd0;
            pkt_cnt_reg   <= 5'd0;
            period_reg    <= P_CTRL;
            ctl_reg       <= 4'b0000;
            pkt_ready_reg <= 1'b0;
            pkt_word_reg  <= 5'd0;
        end else begin
            period_reg    <= base_period_next;
            ctl_reg       <= base_ctl_next;
            pkt_ready_reg <= 1'b0;
            pkt_word_reg  <= 5'd0;
            case (isl_state_reg)
                ISL_IDLE: begin
                    if (x_reg == X_ISL_DECIDE && pkt_valid) begin
                        isl_state_reg <= ISL_PRE;
                        isl_cnt_reg   <= 3'd0;
                        period_reg    <= P_DI_PRE;
                        ctl_reg       <= CTL_DI_PRE;
                    end
                end
                ISL_PRE: begin
                    if (isl_cnt_reg == 3'd7) begin
                        isl_state_reg <= ISL_GBL;
                        isl_cnt_reg   <= 3'd0;
                        period_reg    <= P_DI_GB_LEAD;
                    end else begin
                        isl_cnt_reg   <= isl_cnt_reg + 3'd1;
                        period_reg    <= P_DI_PRE;
                        ctl_reg       <= CTL_DI_PRE;
                    end
                end
                ISL_GBL: begin
                    if (isl_cnt_reg == 3'd1) begin
                        isl_state_reg <= ISL_PKT;
                        pkt_cnt_reg   <= 5'd1;
                        pkt_ready_reg <= 1'b1;
                        period_reg    <= P_DI;
                    end else begin
                        isl_cnt_reg   <= isl_cnt_reg + 3'd1;
                        period_reg    <= P_DI_GB_LEAD;
                    end
                end
                ISL_PKT: begin
                    if (pkt_word_reg == 5'd31) begin
                        if (pkt_valid && (pkt_cnt_reg < PKT_LIMIT)) begin
                            // Back-to-back packet, no gap
                            pkt_cnt_reg   <= pkt_cnt_reg + 5'd1;
                            pkt_ready_reg <= 1'b1;
                            period_reg    <= P_DI;
                        end else begin
                            isl_state_reg <= ISL_GBT;
                            isl_cnt_reg   <= 3'd0;
                            period_reg    <= P_DI_GB_TRAIL;
                        end
                    end else begin
                        pkt_word_reg  <= pkt_word_reg + 5'd1;
                        period_reg    <= P_DI;
                    end
                end
                ISL_GBT: begin
                    if (isl_cnt_reg == 3'd1) begin
                        isl_state_reg <= ISL_IDLE;
                        isl_cnt_reg   <= 3'd0;
                    end else begin
                        isl_cnt_reg   <= isl_cnt_reg + 3'd1;
                        period_reg    <= P_DI_GB_TRAIL;
                    end
                end
                default: begin
                    isl_state_reg <= ISL_IDLE;
                    isl_cnt_reg   <= 3'd0;
                end
            endcase
        end
    end

    assign pkt_ready = pkt_ready_reg;
    assign pkt_word  = pkt_word_reg;

`else

    // DVI mode: no islands, so the packet request has no effect
    logic pkt_valid_unused;
    assign pkt_valid_unused = pkt_valid;

    // Period and control code straight from the raster
    always_ff @(posedge pclk) begin
        if (rst) begin
            period_reg <= P_CTRL;
            ctl_reg    <= 4'b0000;
        end else begin
            period_reg <= base_period_next;
            ctl_reg    <= base_ctl_next;
        end
    end

    assign pkt_ready = 1'b0;
    assign pkt_word  = 5'd0;

`endif

    assign period = period_reg;
    assign ctl    = ctl_reg;
    assign hsync  = hsync_reg;
    assign vsync  = vsync_reg;
    assign de     = de_reg;
    assign x      = x_reg;
    assign y      = y_reg;

endmodule
